rc_tdc_multi: RTL
=================

RC_TDC_MULTI -- requirements
Module: rc_tdc_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of RC channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24, meaning the charge-time counter width.
REQ-003 SHALL have parameter OUT_W, default 8, meaning the resistance result width.
REQ-004 SHALL have parameter SCALE_K, default 1, meaning the unsigned result multiplier replacing 1/(C*ln2).
REQ-005 SHALL have parameter SCALE_SHIFT, default 0, meaning the right shift applied after multiply.
REQ-006 SHALL have parameter DISCH_CYC, default 1024, meaning the discharge hold cycles after each measurement (>=1).
REQ-007 SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-008 SHALL have ports, listed as name direction width meaning:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-pass scan request pulse
- mode_cont  in  1  continuous scanning while high
- ch_mask  in  NUM_CH  enabled channels
- step_in  in  NUM_CH  async comparator inputs
- step_set  out  NUM_CH  RC excitation, at most one bit high
- res_out  out  OUT_W  scaled resistance
- res_ch  out  clog2(NUM_CH) (min 1)  channel of res_out
- res_ovf  out  1  timeout flag of res_out
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- busy  out  1  FSM not IDLE

Function
REQ-009 SHALL pass step_in through a 2-flop synchronizer per bit; all decisions SHALL use synchronized values only.
REQ-010 SHALL implement FSM states IDLE, SELECT, CHARGE, SCALE, RESULT, DISCHARGE.
REQ-011 IDLE: on start=1 or mode_cont=1 with ch_mask!=0, SHALL go to SELECT with scan pointer 0; with ch_mask==0 it SHALL ignore the request.
REQ-012 SELECT (1 cycle): SHALL sample ch_mask and pick the lowest enabled channel >= pointer; if none, SHALL wrap to 0 in continuous mode and return to IDLE otherwise.
REQ-013 CHARGE: SHALL drive step_set[ch]=1 and increment the counter from 0 on the first CHARGE cycle.
REQ-014 CHARGE: when synchronized step_in[ch]=1, SHALL capture the current counter value, clear ovf, and go to SCALE.
REQ-015 CHARGE: when the counter reaches 2^CNT_W-1 without step_in[ch], SHALL capture 2^CNT_W-1, set ovf=1, and go to SCALE.
REQ-016 SCALE (1 cycle, step_set low): SHALL compute (count*SCALE_K)>>SCALE_SHIFT at full precision and saturate the result to 2^OUT_W-1.
REQ-017 RESULT: SHALL hold res_valid=1 with res_out/res_ch/res_ovf stable until res_valid&&res_ready, and SHALL not change them while waiting.
REQ-018 RESULT: SHALL be able to complete the handshake in the first RESULT cycle, giving step_in-to-res_valid latency = 2 sync + 1 capture + 1 SCALE cycles.
REQ-019 DISCHARGE: SHALL hold step_set=0 for exactly DISCH_CYC cycles, advance the pointer to ch+1, then go to SELECT.
REQ-020 SHALL ignore start while busy; if mode_cont falls during a scan, the current channel SHALL complete and the FSM SHALL return to IDLE at the next SELECT unless in a start-initiated pass.
REQ-021 step_set SHALL be nonzero only in CHARGE; busy SHALL be 1 in every state except IDLE.

Reset
REQ-022 reset=1 at any clock edge, in any state including mid-CHARGE, SHALL force IDLE, step_set=0, res_valid=0, res_out=0, res_ch=0, res_ovf=0, busy=0, and clear the counter, pointer, and synchronizers.

Structure
REQ-023 Package rc_tdc_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-024 The synchronizer SHALL be the sub-module rc_tdc_sync2, width-parametrised and instantiated once with NUM_CH bits.

Verification (NUM_CH=4, CNT_W=8, OUT_W=8, DISCH_CYC=16 unless stated)
REQ-025 Basic: K=1, SHIFT=0, mask=0101, start pulse, step_in[0] raised at count=18 -> res_out=20, res_ch=0, res_ovf=0; then ch2 measured; busy falls after ch2 DISCHARGE.
REQ-026 Timeout: mask=0001, step_in held 0 -> res_out=255, res_ovf=1, step_set[0] high for 256 cycles.
REQ-027 Saturation: K=4, SHIFT=0, count=100 -> res_out=255, res_ovf=0; K=3, SHIFT=2, count=100 -> res_out=75.
REQ-028 Backpressure: res_ready=0 for 10 cycles -> res_valid, res_out, res_ch stable and step_set=0 throughout; DISCHARGE starts the cycle after acceptance.
REQ-029 Continuous: mode_cont=1, mask=1011 -> channel order 0,1,3,0,1; step_set is never multi-hot and each ch has a 16-cycle gap.
REQ-030 Reset: reset asserted mid-CHARGE of ch1 -> next cycle all outputs 0, state IDLE, and a following start restarts at ch0.

Source files
------------

// File: rtl/rc_tdc_pkg.sv
// Shared FSM encoding and default parameter values for the RC time-to-digital converter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rc_tdc_pkg;

   localparam int          DEF_NUM_CH      = 4;
   localparam int          DEF_CNT_W       = 24;
   localparam int          DEF_OUT_W       = 8;
   localparam int unsigned DEF_SCALE_K     = 1;
   localparam int          DEF_SCALE_SHIFT = 0;
   localparam int          DEF_DISCH_CYC   = 1024;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SELECT    = 3'd1,
      ST_CHARGE    = 3'd2,
      ST_SCALE     = 3'd3,
      ST_RESULT    = 3'd4,
      ST_DISCHARGE = 3'd5
   } state_t;

endpackage

// File: rtl/rc_tdc_sync2.sv
// Two-flop synchronizer bank for the asynchronous comparator inputs.
// Latency: 2 clk cycles from async_bits to sync_bits.
// Backpressure: none; samples every cycle.
module rc_tdc_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_bits,
   output logic [WIDTH-1:0] sync_bits
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; second stage gives it a full cycle to resolve.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta      <= '0;
         sync_bits <= '0;
      end else begin
         meta      <= async_bits;
         sync_bits <= meta;
      end
   end

endmodule

// File: rtl/rc_tdc_multi.sv
// Multi-channel RC charge-time measurement: scans enabled channels, times each charge, scales to resistance.
// Latency: step_in edge to res_valid = 2 sync + 1 capture + 1 scale cycles.
// Backpressure: result held stable while res_ready is low; scan stalls in RESULT until accepted.
module rc_tdc_multi
   import rc_tdc_pkg::*;
#(
   parameter int          NUM_CH      = DEF_NUM_CH,
   parameter int          CNT_W       = DEF_CNT_W,
   parameter int          OUT_W       = DEF_OUT_W,
   parameter int unsigned SCALE_K     = DEF_SCALE_K,
   parameter int          SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int          DISCH_CYC   = DEF_DISCH_CYC,
   localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode_cont,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [NUM_CH-1:0] step_in,
   output logic [NUM_CH-1:0] step_set,
   output logic [OUT_W-1:0]  res_out,
   output logic [CH_W-1:0]   res_ch,
   output logic              res_ovf,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy
);

   // Pointer must be able to hold NUM_CH (one past the last channel) after a discharge.
   localparam int              PTR_W   = $clog2(NUM_CH + 1);
   localparam int              DC_W    = (DISCH_CYC > 1) ? $clog2(DISCH_CYC) : 1;
   localparam int              PROD_W  = CNT_W + 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [OUT_W-1:0] OUT_MAX = '1;
   localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DISCH_CYC - 1);

   state_t            state;
   logic [NUM_CH-1:0] step_sync;
   logic [CH_W-1:0]   ch;
   logic [PTR_W-1:0]  ptr;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cap_cnt;
   logic              cap_ovf;
   logic [DC_W-1:0]   dcnt;
   logic              single_pass;

   logic              fwd_hit;
   logic              any_hit;
   logic [CH_W-1:0]   fwd_ch;
   logic [CH_W-1:0]   first_ch;
   logic              pick_vld;
   logic [CH_W-1:0]   pick_ch;

   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] shifted;
   logic [OUT_W-1:0]  scaled;

   rc_tdc_sync2 #(.WIDTH(NUM_CH)) u_sync (
      .clk        (clk),
      .reset      (reset),
      .async_bits (step_in),
      .sync_bits  (step_sync)
   );

   // Priority pick: lowest enabled channel at/after the pointer, and lowest enabled overall for wrap.
   always_comb begin
      fwd_hit  = 1'b0;
      any_hit  = 1'b0;
      fwd_ch   = '0;
      first_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            any_hit  = 1'b1;
            first_ch = CH_W'(i);
            if (i >= int'(ptr)) begin
               fwd_hit = 1'b1;
               fwd_ch  = CH_W'(i);
            end
         end
      end
   end

   // A single pass ends at the top of the mask; a continuous scan wraps while mode_cont stays high.
   assign pick_vld = single_pass ? fwd_hit : (mode_cont && any_hit);
   assign pick_ch  = fwd_hit ? fwd_ch : first_ch;

   // Full-precision scaling with saturation to the output width.
   assign prod    = PROD_W'(cap_cnt) * PROD_W'(SCALE_K);
   assign shifted = prod >> SCALE_SHIFT;
   assign scaled  = (shifted > PROD_W'(OUT_MAX)) ? OUT_MAX : shifted[OUT_W-1:0];

   assign busy = (state != ST_IDLE);

   // Scan controller: all outputs registered so step_set is glitch-free on the RC pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         step_set    <= '0;
         res_valid   <= 1'b0;
         res_out     <= '0;
         res_ch      <= '0;
         res_ovf     <= 1'b0;
         ch          <= '0;
         ptr         <= '0;
         cnt         <= '0;
         cap_cnt     <= '0;
         cap_ovf     <= 1'b0;
         dcnt        <= '0;
         single_pass <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if ((start || mode_cont) && (ch_mask != '0)) begin
                  ptr         <= '0;
                  single_pass <= start;
                  state       <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (pick_vld) begin
                  ch       <= pick_ch;
                  cnt      <= '0;
                  step_set <= NUM_CH'(1) << pick_ch;
                  state    <= ST_CHARGE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CHARGE: begin
               if (step_sync[ch]) begin
                  cap_cnt  <= cnt;
                  cap_ovf  <= 1'b0;
                  step_set <= '0;
                  state    <= ST_SCALE;
               end else if (cnt == CNT_MAX) begin
                  cap_cnt  <= CNT_MAX;
                  cap_ovf  <= 1'b1;
                  step_set <= '0;
                  state    <= ST_SCALE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_SCALE: begin
               res_out   <= scaled;
               res_ch    <= ch;
               res_ovf   <= cap_ovf;
               res_valid <= 1'b1;
               state     <= ST_RESULT;
            end
            ST_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  dcnt      <= '0;
                  state     <= ST_DISCHARGE;
               end
            end
            ST_DISCHARGE: begin
               if (dcnt == DC_LAST) begin
                  ptr   <= PTR_W'(ch) + PTR_W'(1);
                  state <= ST_SELECT;
               end else begin
                  dcnt <= dcnt + DC_W'(1);
               end
            end
            default: begin
               step_set <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
